// File: rtl/axi_sram_slave_pkg.sv
// axi_sram_slave_pkg: bus widths shared by the SRAM slave, its bank and the AXI interface
package axi_sram_slave_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_LEN_WIDTH = 8;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(AXI_STRB_WIDTH);
endpackage

// File: rtl/axi4_interface.sv
// axi4_interface: AXI4 channel signals used by the SRAM slave (m_ driven by master, s_ by slave)
interface axi4_interface;
  import axi_sram_slave_pkg::*;
  logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
  logic [AXI_LEN_WIDTH-1:0] m_awlen;
  logic m_awvalid;
  logic s_awready;
  logic [AXI_DATA_WIDTH-1:0] m_wdata;
  logic [AXI_STRB_WIDTH-1:0] m_wstrb;
  logic m_wlast;
  logic m_wvalid;
  logic s_wready;
  logic s_bvalid;
  logic m_bready;
  logic [AXI_ADDR_WIDTH-1:0] m_araddr;
  logic [AXI_LEN_WIDTH-1:0] m_arlen;
  logic m_arvalid;
  logic s_arready;
  logic s_rvalid;
  logic [AXI_DATA_WIDTH-1:0] s_rdata;
  logic m_rready;
  modport slave (
    input m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input m_araddr, m_arlen, m_arvalid, m_rready,
    output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );
endinterface

// File: rtl/axi_sram_bank.sv
// axi_sram_bank: SRAM array with byte-enabled writes and a one-cycle registered read
module axi_sram_bank #(
  parameter int WORDS = 65536,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);
  logic [DATA_WIDTH-1:0] mem [WORDS];
  // byte lanes written only where enabled; contents survive reset
  always_ff @(posedge clk) begin
    if (write_en)
      for (int i = 0; i < DATA_WIDTH / 8; i++)
        if (byte_en[i]) mem[write_addr][8*i +: 8] <= write_data[8*i +: 8];
  end
  // registered read returns the old word on a same-address write
  always_ff @(posedge clk) begin
    if (read_en) read_data <= mem[read_addr];
  end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: zero-wait-state AXI4 slave serving one burst at a time from on-chip SRAM
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int MEM_WORDS = 65536
) (
  input  logic clk,
  input  logic reset,
  axi4_interface.slave axi_bus,
  output logic protocol_error
);
  localparam int WORD_ADDR_WIDTH = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WRITE_BURST, WRITE_RESP, READ_BURST} state_t;
  state_t state_ff;
  logic grant_last_ff;
  logic [WORD_ADDR_WIDTH-1:0] index_ff, aw_index, ar_index, read_addr, next_index;
  logic [AXI_LEN_WIDTH-1:0] beats_ff;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic bvalid_ff, rvalid_ff, perr_ff;
  logic write_grant, read_grant, last_beat, w_hs, r_hs, read_en;
  // grant_last_ff high means read won last, so a contended request goes to write
  assign write_grant = axi_bus.m_awvalid && (!axi_bus.m_arvalid || grant_last_ff);
  assign read_grant = axi_bus.m_arvalid && !write_grant;
  assign axi_bus.s_awready = state_ff == IDLE && write_grant;
  assign axi_bus.s_arready = state_ff == IDLE && read_grant;
  assign axi_bus.s_wready = state_ff == WRITE_BURST;
  assign axi_bus.s_bvalid = bvalid_ff;
  assign axi_bus.s_rvalid = rvalid_ff;
  assign axi_bus.s_rdata = rdata;
  assign protocol_error = perr_ff;
  assign aw_index = WORD_ADDR_WIDTH'(axi_bus.m_awaddr >> BYTE_SHIFT);
  assign ar_index = WORD_ADDR_WIDTH'(axi_bus.m_araddr >> BYTE_SHIFT);
  assign next_index = index_ff + WORD_ADDR_WIDTH'(1);
  assign last_beat = beats_ff == '0;
  assign w_hs = state_ff == WRITE_BURST && axi_bus.m_wvalid;
  assign r_hs = state_ff == READ_BURST && rvalid_ff && axi_bus.m_rready;
  assign read_en = (state_ff == IDLE && read_grant) || state_ff == READ_BURST;
  // a stalled beat re-reads its own word so rdata holds steady
  always_comb begin
    read_addr = state_ff == IDLE ? ar_index : (r_hs && !last_beat) ? next_index : index_ff;
  end
  // transaction FSM with registered response valids and sticky wlast check
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_ff <= IDLE;
      grant_last_ff <= 1'b1;
      index_ff <= '0;
      beats_ff <= '0;
      bvalid_ff <= 1'b0;
      rvalid_ff <= 1'b0;
      perr_ff <= 1'b0;
    end else begin
      case (state_ff)
        IDLE: begin
          if (axi_bus.m_awvalid && axi_bus.m_arvalid) grant_last_ff <= read_grant;
          if (write_grant) begin
            state_ff <= WRITE_BURST;
            index_ff <= aw_index;
            beats_ff <= axi_bus.m_awlen;
          end else if (read_grant) begin
            state_ff <= READ_BURST;
            index_ff <= ar_index;
            beats_ff <= axi_bus.m_arlen;
            rvalid_ff <= 1'b1;
          end
        end
        WRITE_BURST: begin
          if (axi_bus.m_wvalid) begin
            index_ff <= next_index;
            beats_ff <= beats_ff - AXI_LEN_WIDTH'(1);
            if (axi_bus.m_wlast != last_beat) perr_ff <= 1'b1;
            if (last_beat) begin
              state_ff <= WRITE_RESP;
              bvalid_ff <= 1'b1;
            end
          end
        end
        WRITE_RESP: begin
          if (axi_bus.m_bready) begin
            state_ff <= IDLE;
            bvalid_ff <= 1'b0;
          end
        end
        READ_BURST: begin
          if (r_hs) begin
            if (last_beat) begin
              state_ff <= IDLE;
              rvalid_ff <= 1'b0;
            end else begin
              index_ff <= next_index;
              beats_ff <= beats_ff - AXI_LEN_WIDTH'(1);
            end
          end
        end
        default: state_ff <= IDLE;
      endcase
    end
  end
  axi_sram_bank #(
    .WORDS(MEM_WORDS),
    .ADDR_WIDTH(WORD_ADDR_WIDTH),
    .DATA_WIDTH(AXI_DATA_WIDTH)
  ) bank (
    .clk(clk),
    .write_en(w_hs),
    .write_addr(index_ff),
    .write_data(axi_bus.m_wdata),
    .byte_en(axi_bus.m_wstrb),
    .read_en(read_en),
    .read_addr(read_addr),
    .read_data(rdata)
  );
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed bursts against axi_sram_slave with hand-computed expectations
module tb_axi_sram_slave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic perr;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] wbuf [8];
  logic [31:0] rbuf [8];
  axi4_interface bus ();
  axi_sram_slave dut (
    .clk(clk),
    .reset(reset),
    .axi_bus(bus),
    .protocol_error(perr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb, input int last_at);
    @(negedge clk);
    bus.m_awaddr = addr;
    bus.m_awlen = len;
    bus.m_awvalid = 1'b1;
    #1 chk("awready", bus.s_awready, 1);
    @(negedge clk);
    bus.m_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.m_wdata = wbuf[i];
      bus.m_wstrb = strb;
      bus.m_wlast = i == last_at;
      bus.m_wvalid = 1'b1;
      #1 chk("wready", bus.s_wready, 1);
      chk("bvalid_early", bus.s_bvalid, 0);
      @(negedge clk);
    end
    bus.m_wvalid = 1'b0;
    bus.m_wlast = 1'b0;
    chk("bvalid", bus.s_bvalid, 1);
    bus.m_bready = 1'b1;
    @(negedge clk);
    bus.m_bready = 1'b0;
    chk("bvalid_clear", bus.s_bvalid, 0);
  endtask
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input bit toggle);
    int got;
    int cyc;
    @(negedge clk);
    bus.m_araddr = addr;
    bus.m_arlen = len;
    bus.m_arvalid = 1'b1;
    bus.m_rready = 1'b0;
    #1 chk("arready", bus.s_arready, 1);
    @(negedge clk);
    bus.m_arvalid = 1'b0;
    got = 0;
    cyc = 0;
    while (got <= int'(len) && cyc < 64) begin
      bus.m_rready = !toggle || (cyc % 3 == 0);
      chk("rvalid", bus.s_rvalid, 1);
      chk("rdata", bus.s_rdata, rbuf[got]);
      if (bus.m_rready) got++;
      cyc++;
      @(negedge clk);
    end
    bus.m_rready = 1'b0;
    chk("read_beats", got, int'(len) + 1);
    if (!toggle) chk("read_cycles", cyc, int'(len) + 1);
    chk("rvalid_end", bus.s_rvalid, 0);
    bus.m_arvalid = 1'b1;
    #1 chk("arready_next", bus.s_arready, 1);
    bus.m_arvalid = 1'b0;
  endtask
  initial begin
    bus.m_awaddr = '0;
    bus.m_awlen = '0;
    bus.m_awvalid = 1'b0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    bus.m_wlast = 1'b0;
    bus.m_wvalid = 1'b0;
    bus.m_bready = 1'b0;
    bus.m_araddr = '0;
    bus.m_arlen = '0;
    bus.m_arvalid = 1'b0;
    bus.m_rready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_bvalid", bus.s_bvalid, 0);
    chk("reset_rvalid", bus.s_rvalid, 0);
    chk("reset_perr", perr, 0);
    chk("reset_wready", bus.s_wready, 0);
    reset = 1'b0;
    // 8-beat write then full-speed readback
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h11111111 * (i + 1);
    for (int i = 0; i < 8; i++) rbuf[i] = 32'h11111111 * (i + 1);
    do_write(32'h1000, 8'd7, 4'hF, 7);
    chk("perr_clean", perr, 0);
    do_read(32'h1000, 8'd7, 1'b0);
    // same burst with rready 1,0,0 repeating
    do_read(32'h1000, 8'd7, 1'b1);
    // byte strobes merge into existing word
    wbuf[0] = 32'hFFFFFFFF;
    do_write(32'h2000, 8'd0, 4'hF, 0);
    wbuf[0] = 32'hAABBCCDD;
    do_write(32'h2000, 8'd0, 4'b0101, 0);
    rbuf[0] = 32'hFFBBFFDD;
    do_read(32'h2000, 8'd0, 1'b0);
    // write at the top word wraps to word 0
    wbuf[0] = 32'h12345678;
    wbuf[1] = 32'h9ABCDEF0;
    do_write(32'h0003FFFC, 8'd1, 4'hF, 1);
    rbuf[0] = 32'h9ABCDEF0;
    do_read(32'h0, 8'd0, 1'b0);
    rbuf[0] = 32'h12345678;
    rbuf[1] = 32'h9ABCDEF0;
    do_read(32'h0003FFFC, 8'd1, 1'b0);
    // early wlast flags an error but the burst runs its awlen
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0000000 + i;
    for (int i = 0; i < 4; i++) rbuf[i] = 32'hA0000000 + i;
    do_write(32'h4000, 8'd3, 4'hF, 1);
    chk("perr_set", perr, 1);
    do_read(32'h4000, 8'd3, 1'b0);
    chk("perr_sticky", perr, 1);
    // reset during the third beat of a read
    @(negedge clk);
    bus.m_araddr = 32'h1000;
    bus.m_arlen = 8'd7;
    bus.m_arvalid = 1'b1;
    bus.m_rready = 1'b1;
    @(negedge clk);
    bus.m_arvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("beat3_data", bus.s_rdata, 32'h33333333);
    reset = 1'b1;
    #1 chk("reset_drops_rvalid", bus.s_rvalid, 0);
    chk("reset_clears_perr", perr, 0);
    bus.m_rready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.m_arvalid = 1'b1;
    #1 chk("arready_after_reset", bus.s_arready, 1);
    bus.m_arvalid = 1'b0;
    for (int i = 0; i < 8; i++) rbuf[i] = 32'h11111111 * (i + 1);
    do_read(32'h1000, 8'd7, 1'b0);
    // contention from reset alternates W,R,W,R
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.m_awaddr = 32'h3000;
    bus.m_awlen = 8'd0;
    bus.m_araddr = 32'h3000;
    bus.m_arlen = 8'd0;
    bus.m_awvalid = 1'b1;
    bus.m_arvalid = 1'b1;
    bus.m_rready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1 chk("contend_awready", bus.s_awready, 1);
      chk("contend_arready_lo", bus.s_arready, 0);
      @(negedge clk);
      bus.m_wdata = 32'hC0FFEE00 + k;
      bus.m_wstrb = 4'hF;
      bus.m_wlast = 1'b1;
      bus.m_wvalid = 1'b1;
      @(negedge clk);
      bus.m_wvalid = 1'b0;
      bus.m_wlast = 1'b0;
      chk("contend_bvalid", bus.s_bvalid, 1);
      bus.m_bready = 1'b1;
      @(negedge clk);
      bus.m_bready = 1'b0;
      #1 chk("contend_arready", bus.s_arready, 1);
      chk("contend_awready_lo", bus.s_awready, 0);
      @(negedge clk);
      chk("contend_rvalid", bus.s_rvalid, 1);
      chk("contend_rdata", bus.s_rdata, 32'hC0FFEE00 + k);
      @(negedge clk);
      chk("contend_rvalid_end", bus.s_rvalid, 0);
    end
    bus.m_awvalid = 1'b0;
    bus.m_arvalid = 1'b0;
    bus.m_rready = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
